// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared helpers for the RAM port arbiter.
// Optional write-to-read forwarding is compiled in with RAM_ARB_WR_FWD_EN.
package ram_arb_pkg;

    // Index width for N requesters; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Data returned for a read whose address lies outside the RAM.
    localparam int RD_OOR_DATA = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a same-cycle grant.
// The search starts at ptr and wraps; ptr moves past the winner when adv is
// high. Used unchanged with or without RAM_ARB_WR_FWD_EN.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idw_of(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_cand;

    // Scan from ptr+N-1 down to ptr so the candidate nearest ptr wins last.
    always_comb begin
        w_gnt  = '0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (req[w_cand]) begin
                w_gnt = N'(1) << w_cand;
                w_idx = w_cand;
            end
        end
    end

    // Pointer moves one past the winner; it holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign gnt = w_gnt;
    assign idx = w_idx;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the write port (A) and the read port (B) of a
// simple dual-port RAM among NREQ writers and NREQ readers, and returns
// tagged read responses one cycle after the grant.
// Define RAM_ARB_WR_FWD_EN to forward same-cycle write data to a colliding
// read; without it the RAM's read-first (old) data is returned.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 1024,
    parameter  int NREQ  = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int IDW   = idw_of(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // write requesters
    input  logic [NREQ-1:0]       wr_req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       wr_gnt,
    // read requesters
    input  logic [NREQ-1:0]       rd_req,
    input  logic [NREQ*AW-1:0]    rd_addr,
    output logic [NREQ-1:0]       rd_gnt,
    // read responses
    output logic                  rd_valid,
    output logic [IDW-1:0]        rd_id,
    output logic [WIDTH-1:0]      rd_data,
    // RAM port A (write)
    output logic                  ram_write_en_a,
    output logic [AW-1:0]         ram_addr_a,
    output logic [WIDTH-1:0]      ram_data_in_a,
    // RAM port B (read)
    output logic                  ram_read_en_b,
    output logic [AW-1:0]         ram_addr_b,
    input  logic [WIDTH-1:0]      ram_data_out_b
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [NREQ-1:0]  w_wr_gnt_raw;
    logic [NREQ-1:0]  w_rd_gnt_raw;
    logic [NREQ-1:0]  w_wr_gnt;
    logic [NREQ-1:0]  w_rd_gnt;
    logic [IDW-1:0]   w_wr_idx;
    logic [IDW-1:0]   w_rd_idx;
    logic             w_wr_any;
    logic             w_rd_any;
    logic [AW-1:0]    w_wr_addr_sel;
    logic [WIDTH-1:0] w_wr_data_sel;
    logic [AW-1:0]    w_rd_addr_sel;
    logic             w_wr_inr;
    logic             w_rd_inr;
    logic [WIDTH-1:0] w_rd_mem;

    logic             r_rd_valid;
    logic [IDW-1:0]   r_rd_id;
    logic             r_rd_oor;

    // ------------------------------------------------------------------
    // Arbiters. Grants are masked during reset so nothing reaches the RAM.
    // ------------------------------------------------------------------
    rr_arbiter #(.N(NREQ), .IW(IDW)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .adv   (w_wr_any),
        .gnt   (w_wr_gnt_raw),
        .idx   (w_wr_idx)
    );

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .adv   (w_rd_any),
        .gnt   (w_rd_gnt_raw),
        .idx   (w_rd_idx)
    );

    assign w_wr_gnt = rst_n ? w_wr_gnt_raw : '0;
    assign w_rd_gnt = rst_n ? w_rd_gnt_raw : '0;
    assign w_wr_any = |w_wr_gnt;
    assign w_rd_any = |w_rd_gnt;
    assign wr_gnt   = w_wr_gnt;
    assign rd_gnt   = w_rd_gnt;

    // ------------------------------------------------------------------
    // Winner muxes and range checks.
    // ------------------------------------------------------------------
    assign w_wr_addr_sel = wr_addr[int'(w_wr_idx) * AW +: AW];
    assign w_wr_data_sel = wr_data[int'(w_wr_idx) * WIDTH +: WIDTH];
    assign w_rd_addr_sel = rd_addr[int'(w_rd_idx) * AW +: AW];

    assign w_wr_inr = ({1'b0, w_wr_addr_sel} < DEPTH_C);
    assign w_rd_inr = ({1'b0, w_rd_addr_sel} < DEPTH_C);

    // Out-of-range accesses are still granted but never enable the RAM.
    assign ram_write_en_a = w_wr_any & w_wr_inr;
    assign ram_addr_a     = w_wr_any ? w_wr_addr_sel : '0;
    assign ram_data_in_a  = w_wr_any ? w_wr_data_sel : '0;

    assign ram_read_en_b  = w_rd_any & w_rd_inr;
    assign ram_addr_b     = w_rd_any ? w_rd_addr_sel : '0;

    // ------------------------------------------------------------------
    // Response tag stage, aligned with the RAM's one-cycle read.
    // ------------------------------------------------------------------
    // Capture valid, requester id and the out-of-range flag for every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_any;
            r_rd_id    <= w_rd_idx;
            r_rd_oor   <= w_rd_any & ~w_rd_inr;
        end
    end

`ifdef RAM_ARB_WR_FWD_EN
    logic             w_fwd_hit;
    logic             r_fwd_hit;
    logic [WIDTH-1:0] r_fwd_data;

    // Both ports enabled implies both addresses are in range.
    assign w_fwd_hit = ram_write_en_a & ram_read_en_b & (ram_addr_a == ram_addr_b);

    // Hold the colliding write data so the read sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit <= w_fwd_hit;
            if (w_fwd_hit) begin
                r_fwd_data <= ram_data_in_a;
            end
        end
    end

    assign w_rd_mem = r_fwd_hit ? r_fwd_data : ram_data_out_b;
`else
    assign w_rd_mem = ram_data_out_b;
`endif

    assign rd_valid = r_rd_valid;
    assign rd_id    = r_rd_id;
    assign rd_data  = r_rd_oor ? WIDTH'(RD_OOR_DATA) : w_rd_mem;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table, corner-case sequences and a random
// run against a behavioural model. The RAM itself is modelled here as a
// read-first, one-cycle registered-read dual-port memory.
module tb_ram_port_arbiter;

    localparam int W  = 16;
    localparam int D  = 1000;
    localparam int N  = 4;
    localparam int AW = 10;

`ifdef RAM_ARB_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    wr_req  = '0;
    logic [N*AW-1:0] wr_addr = '0;
    logic [N*W-1:0]  wr_data = '0;
    logic [N-1:0]    wr_gnt;
    logic [N-1:0]    rd_req  = '0;
    logic [N*AW-1:0] rd_addr = '0;
    logic [N-1:0]    rd_gnt;
    logic            rd_valid;
    logic [1:0]      rd_id;
    logic [W-1:0]    rd_data;
    logic            ram_write_en_a;
    logic [AW-1:0]   ram_addr_a;
    logic [W-1:0]    ram_data_in_a;
    logic            ram_read_en_b;
    logic [AW-1:0]   ram_addr_b;
    logic [W-1:0]    ram_data_out_b;

    int n_chk  = 0;
    int n_pass = 0;

    ram_port_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_id          (rd_id),
        .rd_data        (rd_data),
        .ram_write_en_a (ram_write_en_a),
        .ram_addr_a     (ram_addr_a),
        .ram_data_in_a  (ram_data_in_a),
        .ram_read_en_b  (ram_read_en_b),
        .ram_addr_b     (ram_addr_b),
        .ram_data_out_b (ram_data_out_b)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, read-first.
    logic [W-1:0] mem [0:1023];
    int           ram_wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_write_en_a) begin
            mem[ram_addr_a] <= ram_data_in_a;
            ram_wr_cnt      <= ram_wr_cnt + 1;
        end
        if (ram_read_en_b) ram_data_out_b <= mem[ram_addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*W +: W]   = W'(d);
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 7) == 0) return 1000 + int'($urandom_range(0, 23));
        return int'($urandom_range(0, 15));
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic [N-1:0] wr;
        logic [N-1:0] rd;
        logic [N-1:0] ewg;
        logic [N-1:0] erg;
    } vec_t;

    vec_t vt [8];

    initial begin
        int gw [N];
        int gr [N];
        int cnt0;

        // Expected grants traced by hand from ptr_wr = ptr_rd = 0 after reset.
        vt[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1] = '{4'b0011, 4'b1000, 4'b0001, 4'b1000};
        vt[2] = '{4'b0011, 4'b0110, 4'b0010, 4'b0010};
        vt[3] = '{4'b0011, 4'b0110, 4'b0001, 4'b0100};
        vt[4] = '{4'b1001, 4'b0110, 4'b1000, 4'b0010};
        vt[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[6] = '{4'b1111, 4'b1111, 4'b0001, 4'b0100};
        vt[7] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

        for (int i = 0; i < N; i++) begin
            set_wr(i, 10 + i, 'hA000 + i);
            set_rd(i, 20 + i);
        end

        // ---- reset state with every requester asserting ----
        rst_n  = 1'b0;
        wr_req = '1;
        rd_req = '1;
        @(negedge clk);
        #1;
        chk("rst_wr_gnt",   32'(wr_gnt), 0);
        chk("rst_rd_gnt",   32'(rd_gnt), 0);
        chk("rst_we_a",     32'(ram_write_en_a), 0);
        chk("rst_re_b",     32'(ram_read_en_b), 0);
        chk("rst_addr_a",   32'(ram_addr_a), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_id",    32'(rd_id), 0);
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- contention: two writers held for four cycles ----
        wr_req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("cont_wr_gnt", 32'(wr_gnt), (c % 2 == 0) ? 1 : 2);
            chk("cont_addr_a", 32'(ram_addr_a), 10 + c % 2);
            chk("cont_we_a",   32'(ram_write_en_a), 1);
            @(negedge clk);
        end
        wr_req = '0;
        chk("cont_mem10", 32'(mem[10]), 'hA000);
        chk("cont_mem11", 32'(mem[11]), 'hA001);

        // ---- table-driven arbitration vectors ----
        do_reset();
        for (int v = 0; v < 8; v++) begin
            wr_req = vt[v].wr;
            rd_req = vt[v].rd;
            #1;
            chk($sformatf("tbl%0d_wr_gnt", v), 32'(wr_gnt), 32'(vt[v].ewg));
            chk($sformatf("tbl%0d_rd_gnt", v), 32'(rd_gnt), 32'(vt[v].erg));
            chk($sformatf("tbl%0d_we_a", v), 32'(ram_write_en_a), 32'(|vt[v].ewg));
            chk($sformatf("tbl%0d_re_b", v), 32'(ram_read_en_b), 32'(|vt[v].erg));
            chk($sformatf("tbl%0d_addr_a", v), 32'(ram_addr_a),
                (|vt[v].ewg) ? 10 + onehot_idx(vt[v].ewg) : 0);
            chk($sformatf("tbl%0d_addr_b", v), 32'(ram_addr_b),
                (|vt[v].erg) ? 20 + onehot_idx(vt[v].erg) : 0);
            @(negedge clk);
        end

        // ---- idle keeps the pointers (wr ptr 3, rd ptr 1) ----
        wr_req = '0;
        rd_req = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("idle_wr_gnt", 32'(wr_gnt), 0);
            chk("idle_rd_gnt", 32'(rd_gnt), 0);
            @(negedge clk);
        end
        wr_req = '1;
        rd_req = '1;
        #1;
        chk("idle_ptr_wr", 32'(wr_gnt), 32'h8);
        chk("idle_ptr_rd", 32'(rd_gnt), 32'h2);

        // ---- fairness: all four requesting for eight cycles ----
        for (int i = 0; i < N; i++) begin gw[i] = 0; gr[i] = 0; end
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                if (wr_gnt[i]) gw[i]++;
                if (rd_gnt[i]) gr[i]++;
            end
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fair_wr%0d", i), 32'(gw[i]), 2);
            chk($sformatf("fair_rd%0d", i), 32'(gr[i]), 2);
        end
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);

        // ---- read latency: mem[5] = BEEF, mem[7] = 1111 ----
        set_wr(0, 5, 'hBEEF);
        wr_req = 4'b0001;
        @(negedge clk);
        set_wr(0, 7, 'h1111);
        @(negedge clk);
        wr_req = '0;
        set_rd(1, 5);
        rd_req = 4'b0010;
        #1;
        chk("lat_rd_gnt", 32'(rd_gnt), 32'h2);
        chk("lat_re_b",   32'(ram_read_en_b), 1);
        chk("lat_addr_b", 32'(ram_addr_b), 5);
        @(negedge clk);
        rd_req = '0;
        chk("lat_valid", 32'(rd_valid), 1);
        chk("lat_id",    32'(rd_id), 1);
        chk("lat_data",  32'(rd_data), 'hBEEF);
        @(negedge clk);
        chk("lat_one_cycle", 32'(rd_valid), 0);

        // ---- same-address write/read collision ----
        set_wr(0, 7, 'h2222);
        set_rd(0, 7);
        wr_req = 4'b0001;
        rd_req = 4'b0001;
        #1;
        chk("col_we_a", 32'(ram_write_en_a), 1);
        chk("col_re_b", 32'(ram_read_en_b), 1);
        @(negedge clk);
        wr_req = '0;
        chk("col_valid", 32'(rd_valid), 1);
        chk("col_data",  32'(rd_data), FWD ? 'h2222 : 'h1111);
        @(negedge clk);
        rd_req = '0;
        chk("col_reread", 32'(rd_data), 'h2222);

        // ---- out of range: write 1005, read 1010 ----
        cnt0 = ram_wr_cnt;
        set_wr(2, 1005, 'h5555);
        set_rd(3, 1010);
        wr_req = 4'b0100;
        rd_req = 4'b1000;
        #1;
        chk("oor_wr_gnt", 32'(wr_gnt), 32'h4);
        chk("oor_rd_gnt", 32'(rd_gnt), 32'h8);
        chk("oor_we_a",   32'(ram_write_en_a), 0);
        chk("oor_re_b",   32'(ram_read_en_b), 0);
        @(negedge clk);
        wr_req = '0;
        rd_req = '0;
        chk("oor_valid",  32'(rd_valid), 1);
        chk("oor_id",     32'(rd_id), 3);
        chk("oor_data",   32'(rd_data), 0);
        chk("oor_no_wr",  32'(ram_wr_cnt), 32'(cnt0));

        // ---- reset pulsed in the cycle after a read grant ----
        set_rd(0, 5);
        rd_req = 4'b0001;
        #1;
        chk("mid_rd_gnt", 32'(rd_gnt), 32'h1);
        @(negedge clk);
        rd_req = '0;
        rst_n  = 1'b0;
        #1;
        chk("mid_valid_rst", 32'(rd_valid), 0);
        chk("mid_id_rst",    32'(rd_id), 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_no_resp", 32'(rd_valid), 0);
        wr_req = '1;
        rd_req = '1;
        #1;
        chk("mid_ptr_wr", 32'(wr_gnt), 32'h1);
        chk("mid_ptr_rd", 32'(rd_gnt), 32'h1);
        @(negedge clk);

        // ---- random traffic against a behavioural model ----
        do_reset();
        begin
            int           pw, pr, w, r, j;
            bit           wact [N];
            bit           ract [N];
            int           wa [N];
            int           wd [N];
            int           ra [N];
            logic [W-1:0] mm [int];
            bit           exp_v, exp_known;
            int           exp_id, exp_d;
            pw = 0; pr = 0;
            exp_v = 0; exp_known = 0; exp_id = 0; exp_d = 0;
            for (int i = 0; i < N; i++) begin
                wact[i] = 0; ract[i] = 0; wa[i] = 0; wd[i] = 0; ra[i] = 0;
            end
            for (int cyc = 0; cyc < 400; cyc++) begin
                chk("rnd_rd_valid", 32'(rd_valid), 32'(exp_v));
                if (exp_v) begin
                    chk("rnd_rd_id", 32'(rd_id), exp_id);
                    if (exp_known) chk("rnd_rd_data", 32'(rd_data), exp_d);
                end
                // a requester keeps its request until it is granted
                for (int i = 0; i < N; i++) begin
                    if (!wact[i]) begin
                        wact[i] = 1'($urandom_range(0, 1));
                        wa[i]   = rnd_addr();
                        wd[i]   = int'($urandom_range(0, 65535));
                    end
                    if (!ract[i]) begin
                        ract[i] = 1'($urandom_range(0, 1));
                        ra[i]   = rnd_addr();
                    end
                    wr_req[i] = wact[i];
                    rd_req[i] = ract[i];
                    set_wr(i, wa[i], wd[i]);
                    set_rd(i, ra[i]);
                end
                #1;
                w = -1;
                r = -1;
                for (int k = 0; k < N; k++) begin
                    j = (pw + k) % N;
                    if (w < 0 && wact[j]) w = j;
                    j = (pr + k) % N;
                    if (r < 0 && ract[j]) r = j;
                end
                chk("rnd_wr_gnt", 32'(wr_gnt), (w >= 0) ? (1 << w) : 0);
                chk("rnd_rd_gnt", 32'(rd_gnt), (r >= 0) ? (1 << r) : 0);
                chk("rnd_we_a", 32'(ram_write_en_a), 32'(w >= 0 && wa[w] < D));
                chk("rnd_re_b", 32'(ram_read_en_b),  32'(r >= 0 && ra[r] < D));
                if (w >= 0) begin
                    chk("rnd_addr_a", 32'(ram_addr_a), wa[w]);
                    chk("rnd_data_a", 32'(ram_data_in_a), wd[w]);
                end else begin
                    chk("rnd_addr_a_idle", 32'(ram_addr_a), 0);
                end
                if (r >= 0 && ra[r] < D) chk("rnd_addr_b", 32'(ram_addr_b), ra[r]);
                // predicted response for next cycle
                exp_v = (r >= 0);
                exp_known = 0;
                if (r >= 0) begin
                    exp_id = r;
                    if (ra[r] >= D) begin
                        exp_d = 0; exp_known = 1;
                    end else if (FWD && w >= 0 && wa[w] == ra[r]) begin
                        exp_d = wd[w]; exp_known = 1;
                    end else if (mm.exists(ra[r])) begin
                        exp_d = int'(mm[ra[r]]); exp_known = 1;
                    end
                end
                if (w >= 0) begin
                    if (wa[w] < D) mm[wa[w]] = W'(wd[w]);
                    pw = (w + 1) % N;
                    wact[w] = 0;
                end
                if (r >= 0) begin
                    pr = (r + 1) % N;
                    ract[r] = 0;
                end
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
